// File: rtl/simon_pkg.sv
// simon_pkg
// Shared definitions for the Simon Says game blocks: colour codes, the
// player-input FSM state encoding, the maximum sequence length and small
// helpers for turning a one-hot button pattern into a colour.
package simon_pkg;

    localparam logic [1:0] COL_0 = 2'd0;
    localparam logic [1:0] COL_1 = 2'd1;
    localparam logic [1:0] COL_2 = 2'd2;
    localparam logic [1:0] COL_3 = 2'd3;

    // Longest colour sequence a round can ask for.
    localparam int SEQ_LEN = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } input_state_t;

    // A press is exactly one button down; clearing the lowest set bit
    // leaves zero only for one-hot patterns.
    function automatic logic is_one_hot(input logic [3:0] b);
        return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
    endfunction

    // Index of the set bit. Only meaningful when is_one_hot(b) holds.
    function automatic logic [1:0] onehot_to_colour(input logic [3:0] b);
        logic [1:0] c;
        c = COL_0;
        if (b[1]) c = COL_1;
        if (b[2]) c = COL_2;
        if (b[3]) c = COL_3;
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Conditions the four raw pushbuttons: a 2-flop synchronizer followed by a
// single stable-pattern counter shared by all four bits. The debounced
// pattern only updates once the synchronized pattern has been unchanged for
// DEBOUNCE_CYCLES clocks.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   buttons  in   raw asynchronous buttons, active-high
//   btn_db   out  debounced button pattern
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] buttons,
    output logic [3:0] btn_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_ff;
    logic [3:0]       btn_s;
    logic [3:0]       btn_prev;
    logic [CNT_W-1:0] stable_cnt;

    // The counter compares the whole 4-bit pattern, so a change on any
    // button restarts the stability window for all of them. Once saturated
    // it keeps reloading btn_db with the (unchanged) synchronized value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff    <= '0;
            btn_s      <= '0;
            btn_prev   <= '0;
            stable_cnt <= '0;
            btn_db     <= '0;
        end else begin
            sync_ff  <= buttons;
            btn_s    <= sync_ff;
            btn_prev <= btn_s;
            if (btn_s != btn_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else begin
                btn_db <= btn_s;
            end
        end
    end

endmodule

// File: rtl/input_state.sv
// input_state
// Player-input phase of a Simon Says round. While en_input is high it
// collects round_ctr+1 debounced presses, compares each to the stored
// sequence, echoes accepted colours, and finishes with exactly one
// complete_input or fail_input pulse (wrong colour or press timeout).
//
// Ports:
//   clk             in   system clock
//   rst_input_n     in   asynchronous active-low reset
//   en_input        in   high = input phase active, low aborts the round
//   buttons         in   raw pushbuttons, buttons[i] = colour i
//   seq_in_input    in   16 packed colours, colour k = bits [2k+1:2k]
//   round_ctr       in   N => N+1 presses expected
//   colour_echo     out  colour of the last accepted press
//   echo_valid      out  high while an accepted button is held
//   complete_input  out  1-cycle pulse, whole round entered correctly
//   fail_input      out  1-cycle pulse, wrong colour or timeout
module input_state
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_input_n,
    input  logic        en_input,
    input  logic [3:0]  buttons,
    input  logic [31:0] seq_in_input,
    input  logic [3:0]  round_ctr,
    output logic [1:0]  colour_echo,
    output logic        echo_valid,
    output logic        complete_input,
    output logic        fail_input
);

    localparam int POS_W = $clog2(SEQ_LEN);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    input_state_t     state, state_next;
    logic [POS_W-1:0] pos, pos_next;
    logic [TO_W-1:0]  timeout_cnt, timeout_next;
    logic             seen_release, seen_release_next;
    logic [1:0]       colour_next;
    logic             echo_next;
    logic             complete_next;
    logic             fail_next;

    logic [3:0] btn_db;
    logic       is_press;
    logic       is_release;
    logic [1:0] press_colour;
    logic [1:0] expected_colour;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_input_n),
        .buttons(buttons),
        .btn_db (btn_db)
    );

    // Multi-bit patterns are neither a press nor a release and are ignored.
    assign is_press        = is_one_hot(btn_db);
    assign is_release      = (btn_db == 4'b0000);
    assign press_colour    = onehot_to_colour(btn_db);
    assign expected_colour = seq_in_input[{pos, 1'b0} +: 2];

    always_ff @(posedge clk or negedge rst_input_n) begin
        if (!rst_input_n) begin
            state          <= IDLE;
            pos            <= '0;
            timeout_cnt    <= '0;
            seen_release   <= 1'b0;
            colour_echo    <= COL_0;
            echo_valid     <= 1'b0;
            complete_input <= 1'b0;
            fail_input     <= 1'b0;
        end else begin
            state          <= state_next;
            pos            <= pos_next;
            timeout_cnt    <= timeout_next;
            seen_release   <= seen_release_next;
            colour_echo    <= colour_next;
            echo_valid     <= echo_next;
            complete_input <= complete_next;
            fail_input     <= fail_next;
        end
    end

    // Dropping en_input aborts from any state without a result pulse.
    // seen_release is cleared at round start so a button already held when
    // the round begins must be released before it can count; it stays set
    // across presses because WAIT_RELEASE only exits on a release.
    // In WAIT_PRESS a valid press is checked before the timeout so a press
    // landing on the last timeout cycle still counts.
    always_comb begin
        state_next        = state;
        pos_next          = pos;
        timeout_next      = timeout_cnt;
        seen_release_next = seen_release;
        colour_next       = colour_echo;
        echo_next         = echo_valid;
        complete_next     = 1'b0;
        fail_next         = 1'b0;

        if (!en_input) begin
            state_next = IDLE;
            echo_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next        = WAIT_PRESS;
                    pos_next          = '0;
                    timeout_next      = '0;
                    seen_release_next = 1'b0;
                    echo_next         = 1'b0;
                end
                WAIT_PRESS: begin
                    timeout_next = timeout_cnt + 1'b1;
                    if (is_release) begin
                        seen_release_next = 1'b1;
                    end
                    if (is_press && seen_release) begin
                        colour_next = press_colour;
                        if (press_colour == expected_colour) begin
                            echo_next  = 1'b1;
                            state_next = WAIT_RELEASE;
                        end else begin
                            fail_next  = 1'b1;
                            state_next = DONE;
                        end
                    end else if (timeout_cnt == TO_MAX) begin
                        fail_next  = 1'b1;
                        state_next = DONE;
                    end
                end
                WAIT_RELEASE: begin
                    if (is_release) begin
                        echo_next = 1'b0;
                        if (pos == round_ctr) begin
                            complete_next = 1'b1;
                            state_next    = DONE;
                        end else begin
                            pos_next     = pos + 1'b1;
                            timeout_next = '0;
                            state_next   = WAIT_PRESS;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
